cpu_seq_decoder: RTL and testbench

Registered, multi-cycle instruction decoder that replaces the combinational two-state decoder in the CPU control path. It latches one instruction word, walks it through up to 2^STEP_W execution steps, and drives one registered control word per step to the datapath (register file, function unit, D/A muxes, memory, stack). It adds three things the current decoder lacks: an accept/ready handshake with the fetch stage, a memory stall that freezes the sequence, and widths set by parameters.

---
 rtl/cpu_ctrl_pkg.sv | 49 ++++
 rtl/cpu_seq_decoder_if.sv | 43 ++++
 rtl/cpu_seq_decode_rom.sv | 123 ++++++++++++
 rtl/cpu_seq_decoder.sv | 171 +++++++++++++++++
 tb/tb_cpu_seq_decoder.sv | 238 +++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_ctrl_pkg.sv
// Shared opcodes, control constants, control-word layout and FSM states for the sequenced decoder.
package cpu_ctrl_pkg;

  // Range opcodes (BRZ/BRN/LDI/STI) only match on OP[6:2]; their low two bits are operand bits.
  localparam logic [6:0] OP_BRZ  = 7'b1011000;
  localparam logic [6:0] OP_BRN  = 7'b1011100;
  localparam logic [6:0] OP_LDI  = 7'b1010000;
  localparam logic [6:0] OP_STI  = 7'b1010100;
  localparam logic [6:0] OP_STR  = 7'b1000101;
  localparam logic [6:0] OP_LRLI = 7'b1000010;
  localparam logic [6:0] OP_BSET = 7'b1001001;
  localparam logic [6:0] OP_BCLR = 7'b1001000;
  localparam logic [6:0] OP_JMPR = 7'b1001101;
  localparam logic [6:0] OP_CALL = 7'b1001110;

  localparam logic [1:0] PS_HOLD = 2'b00;
  localparam logic [1:0] PS_INC  = 2'b01;
  localparam logic [1:0] PS_LOAD = 2'b11;

  localparam logic [4:0] FS_PASS_A = 5'b01100;

  localparam logic [4:0] MUXD_LRLI = 5'b00001;
  localparam logic [4:0] MUXD_CALL = 5'b00010;
  localparam logic [4:0] MUXD_BR   = 5'b00100;

  localparam logic [1:0] SS_PUSH = 2'b01;

  // Longest instruction (LRLI, CALL) in steps.
  localparam int MAX_STEPS = 2;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EXEC,
    ST_STALL
  } state_t;

  // Width-independent part of the per-step control word.
  typedef struct packed {
    logic [1:0] ps;
    logic       ir_l;
    logic       wr;
    logic       clr;
    logic       cin;
    logic       muxa;
    logic       mem_write;
    logic [1:0] ss;
  } ctrl_word_t;

endpackage

// File: rtl/cpu_seq_decoder_if.sv
// Fetch/datapath-facing bundle of the sequenced decoder: instruction handshake, flags, stall and control word.
interface cpu_seq_decoder_if #(
  parameter int DATA_W = 16,
  parameter int REG_AW = 3,
  parameter int STEP_W = 2,
  parameter int FS_W   = 5,
  parameter int MUXD_W = 5
);
  logic [DATA_W-1:0] ir;
  logic              ir_valid;
  logic              ready;
  logic              n;
  logic              z;
  logic              stall;
  logic [1:0]        ps;
  logic              ir_l;
  logic [REG_AW-1:0] aa;
  logic [REG_AW-1:0] ba;
  logic [REG_AW-1:0] da;
  logic              wr;
  logic              clr;
  logic [FS_W-1:0]   fs;
  logic              cin;
  logic [MUXD_W-1:0] muxd;
  logic              muxa;
  logic [DATA_W-1:0] k;
  logic              mem_write;
  logic [1:0]        ss;
  logic [STEP_W-1:0] step;
  logic              done;

  modport master (
    output ir, ir_valid, n, z, stall,
    input  ready, ps, ir_l, aa, ba, da, wr, clr, fs, cin, muxd, muxa, k,
           mem_write, ss, step, done
  );

  modport slave (
    input  ir, ir_valid, n, z, stall,
    output ready, ps, ir_l, aa, ba, da, wr, clr, fs, cin, muxd, muxa, k,
           mem_write, ss, step, done
  );
endinterface

// File: rtl/cpu_seq_decode_rom.sv
// Combinational decode of (instruction, sampled flags, step) into one control word and a last-step flag.
module cpu_seq_decode_rom
  import cpu_ctrl_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int REG_AW = 3,
  parameter int STEP_W = 2,
  parameter int FS_W   = 5,
  parameter int MUXD_W = 5
) (
  input  logic [DATA_W-1:0] ir,
  input  logic              n,
  input  logic              z,
  input  logic [STEP_W-1:0] step,
  output ctrl_word_t        cw,
  output logic [REG_AW-1:0] aa,
  output logic [REG_AW-1:0] ba,
  output logic [REG_AW-1:0] da,
  output logic [FS_W-1:0]   fs,
  output logic [MUXD_W-1:0] muxd,
  output logic [DATA_W-1:0] k,
  output logic              last_step
);

  logic [6:0]        op;
  logic              is_brz;
  logic              is_brn;
  logic              br_taken;
  logic              first_step;
  logic [DATA_W-1:0] bit_mask;

  assign op         = ir[DATA_W-1 -: 7];
  assign is_brz     = (op[6:2] == OP_BRZ[6:2]);
  assign is_brn     = (op[6:2] == OP_BRN[6:2]);
  assign br_taken   = is_brz ? z : n;
  assign first_step = (step == '0);
  assign bit_mask   = DATA_W'(1) << ir[5:2];

  always_comb begin
    cw        = '0;
    aa        = '0;
    ba        = '0;
    da        = '0;
    fs        = '0;
    muxd      = '0;
    k         = '0;
    last_step = 1'b1;

    if (is_brz || is_brn) begin
      if (br_taken) begin
        cw.ps   = PS_LOAD;
        aa      = REG_AW'(ir[10:8]);
        fs      = FS_W'(FS_PASS_A);
        muxd    = MUXD_W'(MUXD_BR);
        cw.muxa = 1'b1;
        k       = DATA_W'(ir[7:0]);
      end else begin
        cw.ps = PS_INC;
      end
    end else if (op[6:2] == OP_LDI[6:2]) begin
      da      = REG_AW'(ir[10:8]);
      k       = DATA_W'(ir[7:0]);
      cw.muxa = 1'b1;
      cw.wr   = 1'b1;
      cw.ps   = PS_INC;
    end else if (op[6:2] == OP_STI[6:2]) begin
      aa           = REG_AW'(ir[10:8]);
      k            = DATA_W'(ir[7:0]);
      cw.mem_write = 1'b1;
      cw.ps        = PS_INC;
    end else if (op == OP_STR) begin
      aa           = REG_AW'(ir[8:6]);
      ba           = REG_AW'(ir[2:0]);
      fs           = FS_W'(FS_PASS_A);
      cw.mem_write = 1'b1;
      cw.ps        = PS_INC;
    end else if (op == OP_BSET || op == OP_BCLR) begin
      // Read-modify-write of one bit; the PC is left alone on this instruction.
      aa    = REG_AW'(ir[8:6]);
      da    = REG_AW'(ir[8:6]);
      k     = (op == OP_BSET) ? bit_mask : ~bit_mask;
      fs    = FS_W'(FS_PASS_A);
      cw.wr = 1'b1;
    end else if (op == OP_JMPR) begin
      aa    = REG_AW'(ir[5:3]);
      k     = DATA_W'(ir[8:0]);
      cw.ps = PS_LOAD;
    end else if (op == OP_LRLI) begin
      last_step = !first_step;
      if (first_step) begin
        muxd  = MUXD_W'(MUXD_LRLI);
        cw.wr = 1'b1;
        da    = REG_AW'(ir[8:6]);
      end else begin
        k       = ir;
        cw.muxa = 1'b1;
        cw.ps   = PS_INC;
      end
    end else if (op == OP_CALL) begin
      last_step = !first_step;
      if (first_step) begin
        cw.ss = SS_PUSH;
        muxd  = MUXD_W'(MUXD_CALL);
        cw.ps = PS_HOLD;
      end else begin
        k     = DATA_W'(ir[8:0]);
        cw.ps = PS_LOAD;
      end
    end else if (!op[6]) begin
      fs    = op[FS_W-1:0];
      da    = REG_AW'(ir[8:6]);
      aa    = REG_AW'(ir[5:3]);
      ba    = REG_AW'(ir[2:0]);
      cw.wr = 1'b1;
      cw.ps = PS_INC;
    end else begin
      cw.ps = PS_INC;
    end

    cw.ir_l = cw.ir_l | last_step;
  end

endmodule

// File: rtl/cpu_seq_decoder.sv
// Registered multi-cycle decoder: accepts one instruction, issues one control word per step, stall freezes the step.
module cpu_seq_decoder
  import cpu_ctrl_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int REG_AW = 3,
  parameter int STEP_W = 2,
  parameter int FS_W   = 5,
  parameter int MUXD_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  cpu_seq_decoder_if.slave  bus
);

  if (MAX_STEPS > (1 << STEP_W)) begin : g_step_w_chk
    $error("STEP_W cannot count the longest instruction");
  end
  if (DATA_W < 16) begin : g_data_w_chk
    $error("DATA_W must be at least 16");
  end
  if (FS_W < 5 || FS_W > 7) begin : g_fs_w_chk
    $error("FS_W must be between 5 and 7");
  end
  if (REG_AW < 3 || MUXD_W < 3) begin : g_field_w_chk
    $error("REG_AW and MUXD_W must be at least 3");
  end

  typedef struct packed {
    ctrl_word_t        cw;
    logic [REG_AW-1:0] aa;
    logic [REG_AW-1:0] ba;
    logic [REG_AW-1:0] da;
    logic [FS_W-1:0]   fs;
    logic [MUXD_W-1:0] muxd;
    logic [DATA_W-1:0] k;
    logic              last;
  } out_t;

  state_t            state_q, state_d;
  logic [STEP_W-1:0] step_q, step_d, rom_step;
  logic [DATA_W-1:0] ir_q, rom_ir;
  logic              n_q, z_q, rom_n, rom_z;
  logic              accept;
  out_t              out_q, out_d, rom_out;

  ctrl_word_t        rom_cw;
  logic [REG_AW-1:0] rom_aa, rom_ba, rom_da;
  logic [FS_W-1:0]   rom_fs;
  logic [MUXD_W-1:0] rom_muxd;
  logic [DATA_W-1:0] rom_k;
  logic              rom_last;

  // A stall on the final step withdraws ready so the step repeats and nothing is accepted.
  assign bus.ready = (state_q == ST_IDLE) ||
                     (state_q == ST_EXEC && out_q.last && !bus.stall);
  assign accept    = bus.ready && bus.ir_valid;

  // The output register is loaded with the word for the step about to be shown next cycle.
  assign rom_ir   = accept ? bus.ir : ir_q;
  assign rom_n    = accept ? bus.n  : n_q;
  assign rom_z    = accept ? bus.z  : z_q;
  assign rom_step = accept ? '0 :
                    (state_q == ST_EXEC) ? step_q + STEP_W'(1) : step_q;

  cpu_seq_decode_rom #(
    .DATA_W (DATA_W),
    .REG_AW (REG_AW),
    .STEP_W (STEP_W),
    .FS_W   (FS_W),
    .MUXD_W (MUXD_W)
  ) u_rom (
    .ir        (rom_ir),
    .n         (rom_n),
    .z         (rom_z),
    .step      (rom_step),
    .cw        (rom_cw),
    .aa        (rom_aa),
    .ba        (rom_ba),
    .da        (rom_da),
    .fs        (rom_fs),
    .muxd      (rom_muxd),
    .k         (rom_k),
    .last_step (rom_last)
  );

  always_comb begin
    rom_out = '{cw: rom_cw, aa: rom_aa, ba: rom_ba, da: rom_da, fs: rom_fs,
                muxd: rom_muxd, k: rom_k, last: rom_last};
  end

  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    out_d   = out_q;
    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d = ST_EXEC;
          step_d  = rom_step;
          out_d   = rom_out;
        end
      end
      ST_EXEC: begin
        if (bus.stall) begin
          // Hold the word but drop every commit so a frozen step cannot write twice.
          state_d            = ST_STALL;
          out_d.cw.wr        = 1'b0;
          out_d.cw.mem_write = 1'b0;
          out_d.cw.ps        = PS_HOLD;
        end else if (!out_q.last || accept) begin
          step_d = rom_step;
          out_d  = rom_out;
        end else begin
          state_d = ST_IDLE;
          step_d  = '0;
          out_d   = '0;
        end
      end
      ST_STALL: begin
        if (!bus.stall) begin
          state_d = ST_EXEC;
          out_d   = rom_out;
        end
      end
      default: begin
        state_d = ST_IDLE;
        step_d  = '0;
        out_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      step_q  <= '0;
      out_q   <= '0;
      ir_q    <= '0;
      n_q     <= 1'b0;
      z_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      out_q   <= out_d;
      if (accept) begin
        ir_q <= bus.ir;
        n_q  <= bus.n;
        z_q  <= bus.z;
      end
    end
  end

  assign bus.ps        = out_q.cw.ps;
  assign bus.ir_l      = out_q.cw.ir_l;
  assign bus.aa        = out_q.aa;
  assign bus.ba        = out_q.ba;
  assign bus.da        = out_q.da;
  assign bus.wr        = out_q.cw.wr;
  assign bus.clr       = out_q.cw.clr;
  assign bus.fs        = out_q.fs;
  assign bus.cin       = out_q.cw.cin;
  assign bus.muxd      = out_q.muxd;
  assign bus.muxa      = out_q.cw.muxa;
  assign bus.k         = out_q.k;
  assign bus.mem_write = out_q.cw.mem_write;
  assign bus.ss        = out_q.cw.ss;
  assign bus.step      = step_q;
  assign bus.done      = out_q.last;

endmodule

// File: tb/tb_cpu_seq_decoder.sv
// Directed bench for cpu_seq_decoder: single-step vector table plus multi-cycle stall/reset/LRLI/CALL sequences.
module tb_cpu_seq_decoder;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  cpu_seq_decoder_if #(.DATA_W(16)) bus16 ();
  cpu_seq_decoder_if #(.DATA_W(32)) bus32 ();

  cpu_seq_decoder #(.DATA_W(16)) dut16 (.clk(clk), .rst(rst), .bus(bus16));
  cpu_seq_decoder #(.DATA_W(32)) dut32 (.clk(clk), .rst(rst), .bus(bus32));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] ir;
    logic        n;
    logic        z;
    logic [1:0]  ps;
    logic        ir_l;
    logic [2:0]  aa;
    logic [2:0]  ba;
    logic [2:0]  da;
    logic        wr;
    logic [4:0]  fs;
    logic [4:0]  muxd;
    logic        muxa;
    logic [15:0] k;
    logic        mem_write;
  } vec_t;

  localparam int NVEC = 14;
  vec_t tbl [NVEC];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic go_idle();
    bus16.ir_valid = 1'b0;
    bus16.stall    = 1'b0;
    tick();
    tick();
  endtask

  initial begin
    //        ir        n     z     ps     irl   aa    ba    da    wr    fs        muxd      muxa  k          mem
    tbl[0]  = '{16'hA412, 1'b0, 1'b0, 2'b01, 1'b1, 3'd0, 3'd0, 3'd4, 1'b1, 5'b00000, 5'b00000, 1'b1, 16'h0012, 1'b0};
    tbl[1]  = '{16'h0AEE, 1'b0, 1'b0, 2'b01, 1'b1, 3'd5, 3'd6, 3'd3, 1'b1, 5'b00101, 5'b00000, 1'b0, 16'h0000, 1'b0};
    tbl[2]  = '{16'hAB7F, 1'b0, 1'b0, 2'b01, 1'b1, 3'd3, 3'd0, 3'd0, 1'b0, 5'b00000, 5'b00000, 1'b0, 16'h007F, 1'b1};
    tbl[3]  = '{16'h8B17, 1'b0, 1'b0, 2'b01, 1'b1, 3'd4, 3'd7, 3'd0, 1'b0, 5'b01100, 5'b00000, 1'b0, 16'h0000, 1'b1};
    tbl[4]  = '{16'hB305, 1'b0, 1'b1, 2'b11, 1'b1, 3'd3, 3'd0, 3'd0, 1'b0, 5'b01100, 5'b00100, 1'b1, 16'h0005, 1'b0};
    tbl[5]  = '{16'hB305, 1'b1, 1'b0, 2'b01, 1'b1, 3'd0, 3'd0, 3'd0, 1'b0, 5'b00000, 5'b00000, 1'b0, 16'h0000, 1'b0};
    tbl[6]  = '{16'hBA07, 1'b1, 1'b0, 2'b11, 1'b1, 3'd2, 3'd0, 3'd0, 1'b0, 5'b01100, 5'b00100, 1'b1, 16'h0007, 1'b0};
    tbl[7]  = '{16'hBA07, 1'b0, 1'b1, 2'b01, 1'b1, 3'd0, 3'd0, 3'd0, 1'b0, 5'b00000, 5'b00000, 1'b0, 16'h0000, 1'b0};
    tbl[8]  = '{16'h9AE8, 1'b0, 1'b0, 2'b11, 1'b1, 3'd5, 3'd0, 3'd0, 1'b0, 5'b00000, 5'b00000, 1'b0, 16'h00E8, 1'b0};
    tbl[9]  = '{16'h938C, 1'b0, 1'b0, 2'b00, 1'b1, 3'd6, 3'd0, 3'd6, 1'b1, 5'b01100, 5'b00000, 1'b0, 16'h0008, 1'b0};
    tbl[10] = '{16'h918C, 1'b0, 1'b0, 2'b00, 1'b1, 3'd6, 3'd0, 3'd6, 1'b1, 5'b01100, 5'b00000, 1'b0, 16'hFFF7, 1'b0};
    tbl[11] = '{16'hC000, 1'b0, 1'b0, 2'b01, 1'b1, 3'd0, 3'd0, 3'd0, 1'b0, 5'b00000, 5'b00000, 1'b0, 16'h0000, 1'b0};
    tbl[12] = '{16'hFE00, 1'b1, 1'b1, 2'b01, 1'b1, 3'd0, 3'd0, 3'd0, 1'b0, 5'b00000, 5'b00000, 1'b0, 16'h0000, 1'b0};
    tbl[13] = '{16'h7E00, 1'b0, 1'b0, 2'b01, 1'b1, 3'd0, 3'd0, 3'd0, 1'b1, 5'b11111, 5'b00000, 1'b0, 16'h0000, 1'b0};

    total = 0;
    bad   = 0;
    bus16.ir = '0; bus16.ir_valid = 1'b0; bus16.n = 1'b0; bus16.z = 1'b0; bus16.stall = 1'b0;
    bus32.ir = '0; bus32.ir_valid = 1'b0; bus32.n = 1'b0; bus32.z = 1'b0; bus32.stall = 1'b0;

    // Reset state
    rst = 1'b1;
    tick();
    tick();
    chk("rst_ready", 32'(bus16.ready), 1);
    chk("rst_ps",    32'(bus16.ps), 0);
    chk("rst_ir_l",  32'(bus16.ir_l), 0);
    chk("rst_wr",    32'(bus16.wr), 0);
    chk("rst_k",     32'(bus16.k), 0);
    chk("rst_step",  32'(bus16.step), 0);
    chk("rst_done",  32'(bus16.done), 0);
    chk("rst_muxd",  32'(bus16.muxd), 0);
    rst = 1'b0;
    tick();
    chk("idle_ready", 32'(bus16.ready), 1);

    // Single-step instructions back to back; flags are flipped after each accept
    for (int i = 0; i < NVEC; i++) begin
      bus16.ir       = tbl[i].ir;
      bus16.n        = tbl[i].n;
      bus16.z        = tbl[i].z;
      bus16.ir_valid = 1'b1;
      tick();
      bus16.n = ~tbl[i].n;
      bus16.z = ~tbl[i].z;
      chk($sformatf("v%0d_ps", i),   32'(bus16.ps), 32'(tbl[i].ps));
      chk($sformatf("v%0d_ir_l", i), 32'(bus16.ir_l), 32'(tbl[i].ir_l));
      chk($sformatf("v%0d_aa", i),   32'(bus16.aa), 32'(tbl[i].aa));
      chk($sformatf("v%0d_ba", i),   32'(bus16.ba), 32'(tbl[i].ba));
      chk($sformatf("v%0d_da", i),   32'(bus16.da), 32'(tbl[i].da));
      chk($sformatf("v%0d_wr", i),   32'(bus16.wr), 32'(tbl[i].wr));
      chk($sformatf("v%0d_fs", i),   32'(bus16.fs), 32'(tbl[i].fs));
      chk($sformatf("v%0d_muxd", i), 32'(bus16.muxd), 32'(tbl[i].muxd));
      chk($sformatf("v%0d_muxa", i), 32'(bus16.muxa), 32'(tbl[i].muxa));
      chk($sformatf("v%0d_k", i),    32'(bus16.k), 32'(tbl[i].k));
      chk($sformatf("v%0d_mem", i),  32'(bus16.mem_write), 32'(tbl[i].mem_write));
      chk($sformatf("v%0d_ss", i),   32'(bus16.ss), 0);
      chk($sformatf("v%0d_step", i), 32'(bus16.step), 0);
      chk($sformatf("v%0d_done", i), 32'(bus16.done), 1);
      chk($sformatf("v%0d_ready", i), 32'(bus16.ready), 1);
    end
    go_idle();
    chk("post_tbl_done", 32'(bus16.done), 0);
    chk("post_tbl_ps",   32'(bus16.ps), 0);

    // LRLI: two steps, ready low on step 0
    bus16.ir = 16'h8485; bus16.ir_valid = 1'b1;
    tick();
    bus16.ir_valid = 1'b0;
    chk("lrli0_muxd",  32'(bus16.muxd), 1);
    chk("lrli0_wr",    32'(bus16.wr), 1);
    chk("lrli0_da",    32'(bus16.da), 2);
    chk("lrli0_ready", 32'(bus16.ready), 0);
    chk("lrli0_done",  32'(bus16.done), 0);
    chk("lrli0_ir_l",  32'(bus16.ir_l), 0);
    tick();
    chk("lrli1_k",     32'(bus16.k), 'h8485);
    chk("lrli1_muxa",  32'(bus16.muxa), 1);
    chk("lrli1_ps",    32'(bus16.ps), 1);
    chk("lrli1_wr",    32'(bus16.wr), 0);
    chk("lrli1_done",  32'(bus16.done), 1);
    chk("lrli1_step",  32'(bus16.step), 1);
    chk("lrli1_ready", 32'(bus16.ready), 1);
    tick();
    chk("lrli_idle_k",    32'(bus16.k), 0);
    chk("lrli_idle_done", 32'(bus16.done), 0);

    // CALL with stall during step 0
    bus16.ir = 16'h9DA5; bus16.ir_valid = 1'b1;
    tick();
    bus16.ir_valid = 1'b0;
    bus16.stall    = 1'b1;
    chk("call0_ss",   32'(bus16.ss), 1);
    chk("call0_muxd", 32'(bus16.muxd), 2);
    chk("call0_ps",   32'(bus16.ps), 0);
    for (int c = 0; c < 3; c++) begin
      tick();
      chk($sformatf("callst%0d_ss", c),    32'(bus16.ss), 1);
      chk($sformatf("callst%0d_muxd", c),  32'(bus16.muxd), 2);
      chk($sformatf("callst%0d_wr", c),    32'(bus16.wr), 0);
      chk($sformatf("callst%0d_mem", c),   32'(bus16.mem_write), 0);
      chk($sformatf("callst%0d_step", c),  32'(bus16.step), 0);
      chk($sformatf("callst%0d_ready", c), 32'(bus16.ready), 0);
    end
    bus16.stall = 1'b0;
    tick();
    chk("call_reissue_ss",   32'(bus16.ss), 1);
    chk("call_reissue_step", 32'(bus16.step), 0);
    tick();
    chk("call1_ps",   32'(bus16.ps), 3);
    chk("call1_k",    32'(bus16.k), 'h01A5);
    chk("call1_ss",   32'(bus16.ss), 0);
    chk("call1_step", 32'(bus16.step), 1);
    chk("call1_done", 32'(bus16.done), 1);
    go_idle();

    // Stall on the final step beats a pending instruction
    bus16.ir = 16'hA412; bus16.ir_valid = 1'b1;
    tick();
    bus16.ir    = 16'hC000;
    bus16.stall = 1'b1;
    #1;
    chk("fstall_ready", 32'(bus16.ready), 0);
    tick();
    chk("fstall_da",    32'(bus16.da), 4);
    chk("fstall_k",     32'(bus16.k), 'h0012);
    chk("fstall_wr",    32'(bus16.wr), 0);
    chk("fstall_ps",    32'(bus16.ps), 0);
    chk("fstall_done",  32'(bus16.done), 1);
    chk("fstall_hold_ready", 32'(bus16.ready), 0);
    bus16.stall = 1'b0;
    tick();
    chk("freissue_wr",    32'(bus16.wr), 1);
    chk("freissue_ps",    32'(bus16.ps), 1);
    chk("freissue_da",    32'(bus16.da), 4);
    chk("freissue_ready", 32'(bus16.ready), 1);
    tick();
    chk("fnext_da", 32'(bus16.da), 0);
    chk("fnext_wr", 32'(bus16.wr), 0);
    chk("fnext_ps", 32'(bus16.ps), 1);
    go_idle();

    // Reset during CALL step 0 aborts it
    bus16.ir = 16'h9DA5; bus16.ir_valid = 1'b1;
    tick();
    bus16.ir_valid = 1'b0;
    chk("callr0_ss", 32'(bus16.ss), 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("callr_ss",    32'(bus16.ss), 0);
    chk("callr_muxd",  32'(bus16.muxd), 0);
    chk("callr_ready", 32'(bus16.ready), 1);
    chk("callr_step",  32'(bus16.step), 0);
    tick();
    chk("callr_no1_ps",   32'(bus16.ps), 0);
    chk("callr_no1_k",    32'(bus16.k), 0);
    chk("callr_no1_done", 32'(bus16.done), 0);

    // 32-bit instance: BSET/BCLR on bit 15
    bus32.ir = 32'h9200_017C; bus32.ir_valid = 1'b1;
    tick();
    chk("bset32_k",  bus32.k, 32'h0000_8000);
    chk("bset32_aa", 32'(bus32.aa), 5);
    chk("bset32_da", 32'(bus32.da), 5);
    chk("bset32_wr", 32'(bus32.wr), 1);
    bus32.ir = 32'h9000_017C;
    tick();
    bus32.ir_valid = 1'b0;
    chk("bclr32_k",    bus32.k, 32'hFFFF_7FFF);
    chk("bclr32_fs",   32'(bus32.fs), 'b01100);
    chk("bclr32_done", 32'(bus32.done), 1);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
